// File: rtl/serial_parity_transmitter.sv
// Serial parity link transmitter: takes a WIDTH-bit word over load/ready and
// sends it LSB first, followed by one parity bit. Define ODD_PARITY_EN for odd frame parity.
module serial_parity_transmitter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             frame,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

`ifdef ODD_PARITY_EN
  localparam logic PAR_INIT = 1'b1;
`else
  localparam logic PAR_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_q;
  logic             ready_q;
  logic             x_out_q;
  logic             frame_q;
  logic             done_q;

  assign ready = ready_q;
  assign x_out = x_out_q;
  assign frame = frame_q;
  assign done  = done_q;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; blocking assignments would let later lines see new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      ready_q <= 1'b1;
      x_out_q <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, PARITY: begin
          if (load) begin
            // Accepting straight out of PARITY gives a gapless back-to-back frame.
            state_q <= DATA;
            shreg_q <= data_in;
            cnt_q   <= '0;
            acc_q   <= data_in[0] ^ PAR_INIT;
            x_out_q <= data_in[0];
            frame_q <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            x_out_q <= 1'b0;
            frame_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        DATA: begin
          if (cnt_q == LAST_DATA) begin
            state_q <= PARITY;
            x_out_q <= acc_q;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            shreg_q <= shreg_q >> 1;
            x_out_q <= shreg_q[1];
            acc_q   <= acc_q ^ shreg_q[1];
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          x_out_q <= 1'b0;
          frame_q <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_transmitter.sv
// Directed bench for serial_parity_transmitter (WIDTH=8): table of words with
// hand-computed frames, plus back-to-back, ignored-load and mid-frame reset sequences.
module tb_serial_parity_transmitter;

  localparam int WIDTH = 8;

`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             frame;
  logic             done;

  int checks;
  int failures;

  serial_parity_transmitter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .x_out   (x_out),
    .frame   (frame),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_frame[8] is the even-parity bit, bits [7:0] go out LSB first.
  typedef struct {
    logic [7:0] data;
    logic [8:0] exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, ".x_out"}, 32'(x_out), 32'd0);
    check({name, ".frame"}, 32'(frame), 32'd0);
    check({name, ".ready"}, 32'(ready), 32'd1);
    check({name, ".done"},  32'(done),  32'd0);
  endtask

  // Called at a negedge; waits (bounded) for ready, then loads across one posedge.
  task automatic accept(input logic [7:0] d);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
    load    = 1'b1;
    data_in = d;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Checks the 9 frame cycles at negedges; optionally pulses a load of 0xFF
  // across the edge ending data cycle pulse_at+1. Ends at the parity-cycle negedge.
  task automatic check_frame(input string name, input logic [8:0] exp, input int pulse_at);
    logic chk;
    logic [8:0] e;
    e = exp;
    e[8] = exp[8] ^ ODD;
    chk = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("%s.x_out[%0d]", name, i), 32'(x_out), 32'(e[i]));
      check($sformatf("%s.frame[%0d]", name, i), 32'(frame), 32'd1);
      check($sformatf("%s.done[%0d]",  name, i), 32'(done),  32'(i == 8));
      check($sformatf("%s.ready[%0d]", name, i), 32'(ready), 32'(i == 8));
      chk = chk ^ x_out;
      if (i == pulse_at) begin
        load    = 1'b1;
        data_in = 8'hFF;
        @(posedge clk);
        #1 load = 1'b0;
      end
    end
    // Moore checker state after the whole frame: 0 for even, 1 for odd parity.
    check({name, ".checker"}, 32'(chk), 32'(ODD));
  endtask

  vec_t vecs[5];

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{data: 8'hA5, exp_frame: 9'h0A5};
    vecs[1] = '{data: 8'h07, exp_frame: 9'h107};
    vecs[2] = '{data: 8'h00, exp_frame: 9'h000};
    vecs[3] = '{data: 8'hFF, exp_frame: 9'h0FF};
    vecs[4] = '{data: 8'h12, exp_frame: 9'h012};

    rst_n   = 1'b0;
    load    = 1'b1;   // reset must win over a simultaneous load
    data_in = 8'hA5;
    repeat (2) @(negedge clk);
    check_idle("reset");
    load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Table-driven single frames from IDLE.
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].data);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_frame, -1);
      @(negedge clk);
      check_idle($sformatf("vec%0d.idle", v));
    end

    // Gapless: load 0x3C held high through the PARITY cycle of a 0x81 frame.
    accept(8'h81);
    load    = 1'b1;
    data_in = 8'h3C;
    check_frame("b2b_81", 9'h081, -1);
    @(posedge clk);
    #1 load = 1'b0;
    check_frame("b2b_3C", 9'h03C, -1);
    @(negedge clk);
    check_idle("b2b.idle");

    // A load pulsed during data cycle 3 of a 0x12 frame is ignored.
    accept(8'h12);
    check_frame("ign_12", 9'h012, 2);
    @(negedge clk);
    check_idle("ign.idle");
    @(negedge clk);
    check_idle("ign.idle2");

    // Asynchronous reset in data cycle 5 of 0xA5, then a clean 0x01 frame.
    accept(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst_A5.x_out[%0d]", i), 32'(x_out), 32'((8'hA5 >> i) & 8'h01));
    end
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release");
    accept(8'h01);
    check_frame("after_rst_01", 9'h101, -1);
    @(negedge clk);
    check_idle("after_rst.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
